// File: rtl/mem_unit_if.sv
// rtl/mem_unit_if.sv - control/bus bundle between the load/store FSM and mem_unit
interface mem_unit_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] bus_in;
   logic              MAR_EN;
   logic              MDR_EN_write;
   logic              MDR_EN_read;
   logic              MDR_out;
   logic              mem_EN;
   logic              mem_RW;
   logic [DATA_W-1:0] bus_out;
   logic              MFC;
   logic              busy;

   modport master (
      output bus_in, MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, mem_EN, mem_RW,
      input  bus_out, MFC, busy
   );

   modport slave (
      input  bus_in, MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, mem_EN, mem_RW,
      output bus_out, MFC, busy
   );
endinterface

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - word-addressed data memory with MAR/MDR and fixed-latency MFC handshake
module mem_unit #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 3
) (
   input logic       clk,
   input logic       rst,
   mem_unit_if.slave bus
);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nx;
   logic              commit;
   logic [ADDR_W-1:0] mar, op_addr;
   logic [DATA_W-1:0] mdr, rd_data, op_data;
   logic              op_rw;
   logic [3:0]        cnt;
   logic              mfc;

   // Contents are deliberately left unreset; only written words are defined.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      commit   = 1'b0;
      case (state)
         IDLE: if (bus.mem_EN) state_nx = BUSY;
         BUSY: begin
            if (!bus.mem_EN) begin
               state_nx = IDLE;
            end else if (cnt == 4'd0) begin
               state_nx = DONE;
               commit   = 1'b1;
            end
         end
         DONE:    if (!bus.mem_EN) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mar     <= '0;
         mdr     <= '0;
         rd_data <= '0;
         op_addr <= '0;
         op_data <= '0;
         op_rw   <= 1'b0;
         cnt     <= 4'd0;
         mfc     <= 1'b0;
      end else begin
         if (bus.MAR_EN) mar <= bus.bus_in[ADDR_W-1:0];
         if (bus.MDR_EN_write)     mdr <= bus.bus_in;
         else if (bus.MDR_EN_read) mdr <= rd_data;
         // Request copies pre-edge MAR/MDR so same-edge loads only affect later accesses.
         if (state == IDLE && bus.mem_EN) begin
            op_addr <= mar;
            op_data <= mdr;
            op_rw   <= bus.mem_RW;
            cnt     <= CNT_INIT;
         end else if (state == BUSY && bus.mem_EN && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit && op_rw) rd_data <= mem[op_addr];
         mfc <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (commit && !op_rw) mem[op_addr] <= op_data;
   end

   assign bus.bus_out = bus.MDR_out ? mdr : '0;
   assign bus.MFC     = mfc;
   assign bus.busy    = (state == BUSY);
endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed table and sequence bench for mem_unit
module tb_mem_unit;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mem_unit_if #(.DATA_W(16)) bus_if ();

   mem_unit #(.ADDR_W(8), .DATA_W(16), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bus;
      logic        mar_en, mdr_w, mdr_r, mdr_o, en, rw;
      logic [15:0] exp_out;
      logic        exp_mfc, exp_busy;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [15:0] b, input logic me, input logic mw, input logic mr,
                        input logic mo, input logic en, input logic rw);
      bus_if.bus_in       = b;
      bus_if.MAR_EN       = me;
      bus_if.MDR_EN_write = mw;
      bus_if.MDR_EN_read  = mr;
      bus_if.MDR_out      = mo;
      bus_if.mem_EN       = en;
      bus_if.mem_RW       = rw;
   endtask

   task automatic do_access(input string tag, input logic load_mar, input logic [7:0] addr,
                            input logic [15:0] data, input logic rw, output logic [15:0] rdata);
      if (load_mar) begin
         apply({8'h00, addr}, 1, 0, 0, 0, 0, 0); tick();
      end
      if (!rw) begin
         apply(data, 0, 1, 0, 0, 0, 0); tick();
      end
      apply(16'h0, 0, 0, 0, 0, 1, rw); tick();
      chk({tag, " req busy"}, bus_if.busy, 1);
      chk({tag, " req mfc"}, bus_if.MFC, 0);
      for (int k = 1; k < LAT; k++) begin
         tick();
         chk({tag, " wait mfc"}, bus_if.MFC, 0);
      end
      tick();
      chk({tag, " mfc at latency"}, bus_if.MFC, 1);
      chk({tag, " busy in done"}, bus_if.busy, 0);
      apply(16'h0, 0, 0, rw, 0, 1, rw); tick();
      apply(16'h0, 0, 0, 0, 1, 0, 0); tick();
      chk({tag, " mfc drop"}, bus_if.MFC, 0);
      rdata = bus_if.bus_out;
      apply(16'h0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [15:0] rd;

      //          bus       me mw mr mo en rw  out       mfc busy
      tbl[0]  = '{16'h0005, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0};
      tbl[1]  = '{16'hBEEF, 0, 1, 0, 1, 0, 0, 16'hBEEF, 0, 0};
      tbl[2]  = '{16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 1};
      tbl[3]  = '{16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 1};
      tbl[4]  = '{16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 1};
      tbl[5]  = '{16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 1, 0};
      tbl[6]  = '{16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0};
      tbl[7]  = '{16'h0000, 0, 1, 0, 1, 0, 0, 16'h0000, 0, 0};
      tbl[8]  = '{16'h0005, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0};
      tbl[9]  = '{16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 1};
      tbl[10] = '{16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 1};
      tbl[11] = '{16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 1};
      tbl[12] = '{16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 1, 0};
      tbl[13] = '{16'h0000, 0, 0, 1, 1, 1, 1, 16'hBEEF, 1, 0};
      tbl[14] = '{16'h0000, 0, 0, 0, 1, 0, 0, 16'hBEEF, 0, 0};
      tbl[15] = '{16'h5A5A, 0, 1, 1, 1, 0, 0, 16'h5A5A, 0, 0};
      tbl[16] = '{16'h0000, 0, 0, 1, 1, 0, 0, 16'hBEEF, 0, 0};

      apply(16'hFFFF, 0, 0, 0, 1, 0, 0);
      tick(); tick();
      chk("reset mfc", bus_if.MFC, 0);
      chk("reset busy", bus_if.busy, 0);
      chk("reset bus_out", bus_if.bus_out, 16'h0000);
      apply(16'h0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].bus, tbl[i].mar_en, tbl[i].mdr_w, tbl[i].mdr_r, tbl[i].mdr_o,
               tbl[i].en, tbl[i].rw);
         tick();
         chk($sformatf("vec%0d bus_out", i), bus_if.bus_out, tbl[i].exp_out);
         chk($sformatf("vec%0d mfc", i), bus_if.MFC, tbl[i].exp_mfc);
         chk($sformatf("vec%0d busy", i), bus_if.busy, tbl[i].exp_busy);
      end
      apply(16'h0, 0, 0, 0, 0, 0, 0); tick();

      // abort: write dropped after one BUSY cycle leaves memory untouched
      do_access("abort pre", 1, 8'h10, 16'h1111, 0, rd);
      apply(16'h0010, 1, 0, 0, 0, 0, 0); tick();
      apply(16'h00AA, 0, 1, 0, 0, 0, 0); tick();
      apply(16'h0000, 0, 0, 0, 0, 1, 0); tick();
      tick();
      apply(16'h0000, 0, 0, 0, 0, 0, 0); tick();
      chk("abort busy", bus_if.busy, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("abort mfc", bus_if.MFC, 0);
      end
      do_access("abort rd", 1, 8'h10, 16'h0, 1, rd);
      chk("abort data", rd, 16'h1111);

      // held mem_EN through DONE with changing inputs: one access only
      apply(16'h0020, 1, 0, 0, 0, 0, 0); tick();
      apply(16'h7777, 0, 1, 0, 0, 0, 0); tick();
      apply(16'h0000, 0, 0, 0, 0, 1, 0); tick();
      for (int k = 1; k < LAT; k++) tick();
      tick();
      chk("held mfc rise", bus_if.MFC, 1);
      for (int k = 0; k < 10; k++) begin
         apply(16'h8888, 0, 1, 0, 0, 1, 1); tick();
         chk("held mfc", bus_if.MFC, 1);
         chk("held busy", bus_if.busy, 0);
      end
      apply(16'h0000, 0, 0, 0, 0, 0, 0); tick();
      chk("held mfc fall", bus_if.MFC, 0);
      do_access("held rd", 1, 8'h20, 16'h0, 1, rd);
      chk("held data", rd, 16'h7777);

      // same-edge MAR load: access uses old MAR, new MAR takes low byte only
      do_access("se pre22", 1, 8'h22, 16'hAAAA, 0, rd);
      do_access("se pre30", 1, 8'h30, 16'hBBBB, 0, rd);
      apply(16'h0030, 1, 0, 0, 0, 0, 0); tick();
      apply(16'h1357, 0, 1, 0, 0, 0, 0); tick();
      apply(16'hFF22, 1, 0, 0, 0, 1, 0); tick();
      apply(16'h0000, 0, 0, 0, 0, 1, 0);
      for (int k = 1; k < LAT; k++) tick();
      tick();
      chk("se mfc", bus_if.MFC, 1);
      apply(16'h0000, 0, 0, 0, 0, 0, 0); tick();
      do_access("se rd cur", 0, 8'h00, 16'h0, 1, rd);
      chk("se mar 22", rd, 16'hAAAA);
      do_access("se rd30", 1, 8'h30, 16'h0, 1, rd);
      chk("se data30", rd, 16'h1357);

      // asynchronous reset mid-BUSY discards the write
      do_access("rst pre", 1, 8'h40, 16'h0F0F, 0, rd);
      apply(16'h0040, 1, 0, 0, 0, 0, 0); tick();
      apply(16'h1234, 0, 1, 0, 1, 0, 0); tick();
      chk("rst mdr", bus_if.bus_out, 16'h1234);
      apply(16'h0000, 0, 0, 0, 1, 1, 0); tick();
      tick();
      chk("rst pre busy", bus_if.busy, 1);
      rst = 1'b0;
      #1;
      chk("rst async mfc", bus_if.MFC, 0);
      chk("rst async busy", bus_if.busy, 0);
      chk("rst async bus_out", bus_if.bus_out, 16'h0000);
      apply(16'h0000, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rst after mfc", bus_if.MFC, 0);
      end
      do_access("rst rd", 1, 8'h40, 16'h0, 1, rd);
      chk("rst data", rd, 16'h0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_unit.md
# mem_unit

Word-addressed data memory with MAR/MDR registers and an MFC (memory-function-complete) handshake. It sits directly downstream of the load/store control FSM. It consumes that FSM's MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, mem_EN and mem_RW strobes, exchanges data with the shared 16-bit bus, and returns MFC after a fixed access latency.

## Interface
- ADDR_W, 8, address width; memory depth is 2^ADDR_W words
- DATA_W, 16, word and bus width
- LATENCY, 3, cycles from mem_EN sampled high to MFC high; legal range 1..15
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- bus_in  in  DATA_W  shared bus value (address or data)
- MAR_EN  in  1  load MAR from bus_in[ADDR_W-1:0]
- MDR_EN_write  in  1  load MDR from bus_in
- MDR_EN_read  in  1  load MDR from read-data register
- MDR_out  in  1  drive MDR onto bus_out
- mem_EN  in  1  request/hold a memory access
- mem_RW  in  1  1 = read, 0 = write; sampled at request
- bus_out  out  DATA_W  MDR when MDR_out=1, else 0 (combinational)
- MFC  out  1  access complete, registered
- busy  out  1  high in BUSY state, registered-state decode

## Operation
- Registers:
  - MAR (ADDR_W): bus_in bits above ADDR_W-1 are ignored.
  - MDR (DATA_W).
  - rd_data (DATA_W).
  - op_addr, op_data, op_rw: latched request copy.
  - cnt (4 bits).
  - state.
- MDR load priority: MDR_EN_write over MDR_EN_read when both are high.
- Memory array is not reset; its contents are undefined until written.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_EN=1, latch op_addr<=MAR, op_data<=MDR, op_rw<=mem_RW, cnt<=LATENCY-1, then go to BUSY.
  - MAR/MDR values used are the pre-edge values. A MAR_EN or MDR_EN_write on the same edge affects only later operations.
- BUSY:
  - If mem_EN=0: abort. Return to IDLE with no memory write and no rd_data change.
  - Else if cnt=0: perform the access and go to DONE with MFC<=1.
    - Write: mem[op_addr]<=op_data.
    - Read: rd_data<=mem[op_addr].
  - Else cnt<=cnt-1.
- DONE:
  - MFC held at 1 while mem_EN=1. MDR_EN_read here loads the fresh rd_data.
  - When mem_EN=0: go to IDLE, MFC<=0.
- Changes to mem_RW, MAR or MDR after the request edge do not affect the in-flight operation.
- A new request requires mem_EN low for at least one sampled edge after DONE. mem_EN held high through DONE never starts a second access.
- MDR_EN_read outside DONE loads whatever rd_data holds (stale value); this is legal and defined.

## Timing
- Reset (rst=0, asynchronous) values:
  - state=IDLE, MFC=0, busy=0.
  - MAR=0, MDR=0, rd_data=0, cnt=0.
  - op_addr/op_data/op_rw=0.
  - bus_out=0.
- Reset mid-operation discards the access; no memory write occurs if reset precedes the commit edge.
- Request sampled at edge E0 → MFC rises after edge E(LATENCY), i.e. LATENCY cycles later.
  - LATENCY=1: MFC rises after the next edge.
- Write commit and rd_data update occur on the same edge that raises MFC.
- MFC falls on the first edge at which mem_EN=0 is sampled in DONE.
- MAR, MDR and rd_data update on the edge at which their enable is sampled high; bus_out follows MDR the same cycle.
- Read-after-write to the same address is correct for back-to-back operations: the write commits before the later read is sampled.

## Test plan
- Reset: drive rst=0 mid-BUSY with MDR=16'h1234 → MFC=0, busy=0, bus_out=0 immediately. A subsequent read of that address returns its pre-reset contents; no write occurred.
- Store then load, LATENCY=3:
  - Store: MAR←8'h05, MDR←16'hBEEF, mem_EN=1, mem_RW=0 → MFC high exactly 3 cycles after the request edge.
  - Load: drop mem_EN, MDR←0, MAR←8'h05, mem_EN=1, mem_RW=1, wait MFC, pulse MDR_EN_read, MDR_out=1 → bus_out=16'hBEEF.
- Abort: start a write of 16'h00AA to 8'h10, drop mem_EN after 1 BUSY cycle → MFC never rises; a read of 8'h10 returns the prior value.
- Held mem_EN: keep mem_EN=1 for 10 cycles past MFC → MFC stays 1, exactly one access performed, MFC falls on the first edge with mem_EN=0.
- Same-edge update: MAR_EN with bus_in=16'hFF22 on the request edge → access uses the old MAR. MAR becomes 8'h22 afterwards; upper bus bits are ignored.
- Priority: MDR_EN_write=1 and MDR_EN_read=1 together with bus_in=16'h5A5A → MDR=16'h5A5A.
